// File: rtl/ni_output_arbiter_if.sv
// Requester, injection and status bundle between the NI output arbiter and its neighbours.
`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 32
`endif

interface ni_output_arbiter_if #(
  parameter int unsigned CW = 3
);
  logic                     rd_valid;
  logic [`ROUTER_WIDTH-1:0] rd_flit;
  logic                     rd_ready;
  logic                     act_valid;
  logic [`ROUTER_WIDTH-1:0] act_flit;
  logic                     act_ready;
  logic                     fin_valid;
  logic [`ROUTER_WIDTH-1:0] fin_flit;
  logic                     fin_ready;
  logic                     downstream_credit;
  logic                     out_data_valid;
  logic [`ROUTER_WIDTH-1:0] out_data;
  logic [CW-1:0]            credit_cnt;
  logic                     fin_done;
  logic                     credit_err;

  // Arbiter side
  modport slave (
    input  rd_valid, rd_flit, act_valid, act_flit, fin_valid, fin_flit, downstream_credit,
    output rd_ready, act_ready, fin_ready, out_data_valid, out_data, credit_cnt,
    output fin_done, credit_err
  );

  // Requester / router side
  modport master (
    output rd_valid, rd_flit, act_valid, act_flit, fin_valid, fin_flit, downstream_credit,
    input  rd_ready, act_ready, fin_ready, out_data_valid, out_data, credit_cnt,
    input  fin_done, credit_err
  );
endinterface

// File: rtl/ni_output_arbiter.sv
// Credit-based arbiter injecting read-response, activation and finish flits into the router.
`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 32
`endif

module ni_output_arbiter #(
  parameter int unsigned CREDIT_DEPTH = 4,
  parameter int unsigned CW           = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  ni_output_arbiter_if.slave   bus
);
  localparam int unsigned FW = `ROUTER_WIDTH;
  localparam logic [CW-1:0] FULL = CW'(CREDIT_DEPTH);

  typedef enum logic {RUN = 1'b0, FIN_WAIT = 1'b1} state_e;

  state_e          state_q, state_d;
  logic            rr_q, rr_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic            out_valid_q, out_valid_d;
  logic [FW-1:0]   out_data_q, out_data_d;
  logic            fin_done_q, fin_done_d;
  logic            credit_err_q, credit_err_d;

  logic            can_grant, rd_gnt, act_gnt, fin_gnt, any_gnt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (fin_gnt) state_d = FIN_WAIT;
      FIN_WAIT: if (credit_d == FULL) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Grants, credit accounting and injection datapath
  always_comb begin
    can_grant    = !rst && (state_q == RUN) && (credit_q != '0);
    rd_gnt       = can_grant && bus.rd_valid && (!bus.act_valid || !rr_q);
    act_gnt      = can_grant && bus.act_valid && (!bus.rd_valid || rr_q);
    fin_gnt      = can_grant && bus.fin_valid && !bus.rd_valid && !bus.act_valid;
    any_gnt      = rd_gnt || act_gnt || fin_gnt;

    rr_d         = rr_q;
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    out_valid_d  = any_gnt;
    out_data_d   = '0;

    if (rd_gnt) begin
      rr_d       = 1'b1;
      out_data_d = bus.rd_flit;
    end else if (act_gnt) begin
      rr_d       = 1'b0;
      out_data_d = bus.act_flit;
    end else if (fin_gnt) begin
      out_data_d = bus.fin_flit;
    end

    // Simultaneous grant and returned credit cancel out
    if (any_gnt && !bus.downstream_credit) begin
      credit_d = credit_q - CW'(1);
    end else if (!any_gnt && bus.downstream_credit) begin
      if (credit_q == FULL) credit_err_d = 1'b1;
      else                  credit_d     = credit_q + CW'(1);
    end

    fin_done_d = (state_q == FIN_WAIT) && (credit_d == FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q         <= 1'b0;
      credit_q     <= FULL;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      fin_done_q   <= 1'b0;
      credit_err_q <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      credit_q     <= credit_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      fin_done_q   <= fin_done_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign bus.rd_ready       = rd_gnt;
  assign bus.act_ready      = act_gnt;
  assign bus.fin_ready      = fin_gnt;
  assign bus.out_data_valid = out_valid_q;
  assign bus.out_data       = out_data_q;
  assign bus.credit_cnt     = credit_q;
  assign bus.fin_done       = fin_done_q;
  assign bus.credit_err     = credit_err_q;
endmodule
